prod_accumulator: RTL and testbench



---
 rtl/prod_acc_pkg.sv | 26 ++
 rtl/acc_add_sat.sv | 34 +++
 rtl/prod_accumulator.sv | 103 ++++++++++
 tb/tb_prod_accumulator.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// ============================================================================
// Module  : prod_acc_pkg
// Brief   : Shared constants, FSM state encodings and counter helper for the
//           product accumulator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package prod_acc_pkg;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = {64{1'b1}} >> (64 - w);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_add_sat.sv
// ============================================================================
// Module  : acc_add_sat
// Brief   : Combinational accumulator + zero-extended product adder with
//           overflow flag. Clamps to all-ones when PROD_ACC_SAT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_add_sat
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    assign full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign ovf  = full[ACC_W];

`ifdef PROD_ACC_SAT_EN
    // Once clamped, any further non-zero beat overflows again and re-clamps.
    assign sum = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/prod_accumulator.sv
// ============================================================================
// Module  : prod_accumulator
// Brief   : Sums 32-bit multiplier products of a packet into a wide register
//           and presents the registered total on a valid/ready result port.
//           Optional clamp on overflow: define PROD_ACC_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      prod_lo,
    input  logic [15:0]      prod_hi,
    input  logic             prod_of,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_err
);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_f;
    logic             err_f;

    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt_inc;

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc),
        .prod ({prod_hi, prod_lo}),
        .sum  (sum),
        .ovf  (ovf)
    );

    assign cnt_inc  = CNT_W'(sat_inc(64'(cnt), CNT_W));
    assign in_ready = (state == ST_ACC) & ~clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            sat_f     <= 1'b0;
            err_f     <= 1'b0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else if (state == ST_ACC) begin
            if (clear) begin
                acc   <= '0;
                cnt   <= '0;
                sat_f <= 1'b0;
                err_f <= 1'b0;
            end else if (in_valid) begin
                if (in_last) begin
                    acc_out   <= sum;
                    out_count <= cnt_inc;
                    out_sat   <= sat_f | ovf;
                    out_err   <= err_f | prod_of;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sat_f     <= 1'b0;
                    err_f     <= 1'b0;
                    state     <= ST_HOLD;
                end else begin
                    acc   <= sum;
                    cnt   <= cnt_inc;
                    sat_f <= sat_f | ovf;
                    err_f <= err_f | prod_of;
                end
            end
        end else begin
            // Result stays frozen until the consumer takes it; clear is ignored here.
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= ST_ACC;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prod_accumulator.sv
// ============================================================================
// Module  : tb_prod_accumulator
// Brief   : Directed self-checking bench for prod_accumulator (ACC_W=40 and
//           ACC_W=34 instances). Honours PROD_ACC_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prod_lo, prod_hi;
    logic        prod_of, in_valid, in_last, clear, out_ready;
    logic        in_ready, out_valid, out_sat, out_err;
    logic [39:0] acc_out;
    logic [7:0]  out_count;

    logic [15:0] s_lo, s_hi;
    logic        s_valid, s_last;
    logic        s_in_ready, s_out_valid, s_sat, s_err;
    logic [33:0] s_acc;
    logic [7:0]  s_count;

    int total  = 0;
    int passed = 0;

    logic [39:0] held;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .prod_lo(prod_lo), .prod_hi(prod_hi),
        .prod_of(prod_of), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .out_count(out_count),
        .out_sat(out_sat), .out_err(out_err)
    );

    prod_accumulator #(.ACC_W(34), .CNT_W(8)) dut34 (
        .clk(clk), .rst_n(rst_n), .prod_lo(s_lo), .prod_hi(s_hi),
        .prod_of(1'b0), .in_valid(s_valid), .in_last(s_last),
        .in_ready(s_in_ready), .clear(1'b0), .out_valid(s_out_valid),
        .out_ready(1'b1), .acc_out(s_acc), .out_count(s_count),
        .out_sat(s_sat), .out_err(s_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p, input logic last, input logic of);
        prod_lo  = p[15:0];
        prod_hi  = p[31:16];
        in_last  = last;
        prod_of  = of;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        prod_of  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; prod_lo = '0; prod_hi = '0; prod_of = 1'b0;
        in_valid = 1'b1; in_last = 1'b0; clear = 1'b0; out_ready = 1'b1;
        s_lo = '0; s_hi = '0; s_valid = 1'b0; s_last = 1'b0;
        prod_lo = 16'h1234;

        // Reset held two cycles with a valid beat presented
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_acc_out",   64'(acc_out),   64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Three-beat packet
        beat(32'h0000_0006, 1'b0, 1'b0);
        beat(32'h0001_0000, 1'b0, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("p1_valid", 64'(out_valid), 64'd1);
        chk("p1_acc",   64'(acc_out),   64'h01_0001_0005);
        chk("p1_count", 64'(out_count), 64'd3);
        chk("p1_sat",   64'(out_sat),   64'd0);
        chk("p1_err",   64'(out_err),   64'd0);

        // Backpressure: result held while a last beat waits
        out_ready = 1'b0;
        prod_lo = 16'h0007; prod_hi = 16'h0000; in_last = 1'b1; in_valid = 1'b1;
        held = 40'h01_0001_0005;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_acc",      64'(acc_out),   64'(held));
        end
        out_ready = 1'b1;
        step();
        chk("bp_hs_valid", 64'(out_valid), 64'd0);
        chk("bp_hs_ready", 64'(in_ready),  64'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_next_acc",   64'(acc_out),   64'd7);
        chk("bp_next_count", 64'(out_count), 64'd1);
        step();

        // Mid-packet clear
        beat(32'h10, 1'b0, 1'b0);
        beat(32'h20, 1'b0, 1'b0);
        clear = 1'b1; in_valid = 1'b1; prod_lo = 16'h0099;
        #1;
        chk("clr_in_ready", 64'(in_ready), 64'd0);
        step();
        clear = 1'b0; in_valid = 1'b0;
        beat(32'h5, 1'b1, 1'b0);
        chk("clr_acc",   64'(acc_out),   64'd5);
        chk("clr_count", 64'(out_count), 64'd1);
        step();

        // Same abort via reset
        beat(32'h10, 1'b0, 1'b0);
        beat(32'h20, 1'b0, 1'b0);
        rst_n = 1'b0; in_valid = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        beat(32'h5, 1'b1, 1'b0);
        chk("rstab_acc",   64'(acc_out),   64'd5);
        chk("rstab_count", 64'(out_count), 64'd1);
        step();

        // Error flag is sticky within a packet only
        beat(32'h1, 1'b0, 1'b1);
        beat(32'h2, 1'b1, 1'b0);
        chk("err_acc",  64'(acc_out), 64'd3);
        chk("err_flag", 64'(out_err), 64'd1);
        chk("err_sat",  64'(out_sat), 64'd0);
        step();
        beat(32'h4, 1'b1, 1'b0);
        chk("err_clean_flag", 64'(out_err), 64'd0);
        chk("err_clean_acc",  64'(acc_out), 64'd4);
        step();

        // Beat counter saturates at 255
        for (int i = 0; i < 260; i++) beat(32'h1, (i == 259), 1'b0);
        chk("cnt_sat_count", 64'(out_count), 64'd255);
        chk("cnt_sat_acc",   64'(acc_out),   64'd260);
        step();

        // ACC_W=34 overflow with five all-ones beats
        s_lo = 16'hFFFF; s_hi = 16'hFFFF; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_last = (i == 4);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("w34_valid", 64'(s_out_valid), 64'd1);
        chk("w34_sat",   64'(s_sat),       64'd1);
        chk("w34_count", 64'(s_count),     64'd5);
        chk("w34_err",   64'(s_err),       64'd0);
`ifdef PROD_ACC_SAT_EN
        chk("w34_acc", 64'(s_acc), 64'h3_FFFF_FFFF);
`else
        chk("w34_acc", 64'(s_acc), 64'h0_FFFF_FFFB);
`endif
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
